conv_mac_stream: RTL and testbench

Streaming, pipelined successor to the single-cycle 3x3 FPUMAC. Accepts one image column per cycle over a valid/ready handshake and keeps a sliding window of KSIZE columns. Once the window is full, it produces COL_WIDTH-KSIZE+1 output pixels per accepted column, using a loadable signed KSIZE x KSIZE filter, with programmable right-shift, optional absolute value and unsigned saturation. It sits between the column line buffer and the output pixel writer in the filter datapath.

---
 rtl/conv_mac_stream.sv | 145 ++++++++++++++
 tb/tb_conv_mac_stream.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_stream.sv
// Streaming KSIZE x KSIZE signed convolution over a sliding window of image columns.
// Three-stage pipeline (window, products, sum/shift/abs/saturate) with valid/ready on both sides.
module conv_mac_stream #(
   parameter int COL_WIDTH = 10,
   parameter int KSIZE     = 3,
   parameter int PIX_W     = 8,
   parameter int COEF_W    = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           filt_wr,
   input  logic [$clog2(KSIZE*KSIZE)-1:0] filt_addr,
   input  logic signed [COEF_W-1:0]       filt_data,
   input  logic [3:0]                     shift,
   input  logic                           abs_en,
   input  logic                           col_valid,
   output logic                           col_ready,
   input  logic [PIX_W-1:0]               col_in [COL_WIDTH],
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [PIX_W-1:0]               out_pixels [COL_WIDTH-KSIZE+1]
);
   localparam int NTAP   = KSIZE * KSIZE;
   localparam int NOUT   = COL_WIDTH - KSIZE + 1;
   localparam int PROD_W = PIX_W + 1 + COEF_W;
   localparam int SUM_W  = PROD_W + $clog2(NTAP);
   localparam int FILL_W = $clog2(KSIZE + 1);
   localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(KSIZE);
   localparam logic signed [SUM_W-1:0] PIX_MAX   = SUM_W'((1 << PIX_W) - 1);

   logic [PIX_W-1:0]         win [KSIZE][COL_WIDTH];
   logic signed [COEF_W-1:0] coef [NTAP];
   logic [FILL_W-1:0]        fill;
   logic                     win_v;
   logic                     p_v;
   logic                     stall;
   logic                     accept;
   logic                     window_event;
   logic [PIX_W-1:0]         res [NOUT];

   function automatic logic [PIX_W-1:0] post_proc(input logic signed [SUM_W-1:0] s,
                                                  input logic [3:0] sh,
                                                  input logic ab);
      logic signed [SUM_W-1:0] v;
      v = s >>> sh;
      if (ab && v[SUM_W-1])
         v = -v;
      if (v[SUM_W-1])
         post_proc = '0;
      else if (v > PIX_MAX)
         post_proc = '1;
      else
         post_proc = v[PIX_W-1:0];
   endfunction

   assign stall        = out_valid && !out_ready;
   assign col_ready    = !stall && !flush;
   assign accept       = col_valid && col_ready;
   // The accept that brings fill up to (or keeps it at) KSIZE completes a window.
   assign window_event = accept && (fill >= FILL_FULL - 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAP; i++)
            coef[i] <= '0;
      end else if (filt_wr && (32'(filt_addr) < NTAP)) begin
         coef[filt_addr] <= filt_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill  <= '0;
         win_v <= 1'b0;
         for (int c = 0; c < KSIZE; c++)
            for (int i = 0; i < COL_WIDTH; i++)
               win[c][i] <= '0;
      end else if (flush) begin
         fill  <= '0;
         win_v <= 1'b0;
      end else if (!stall) begin
         win_v <= window_event;
         if (accept) begin
            if (fill != FILL_FULL)
               fill <= fill + 1'b1;
            for (int c = 0; c < KSIZE - 1; c++)
               for (int i = 0; i < COL_WIDTH; i++)
                  win[c][i] <= win[c+1][i];
            for (int i = 0; i < COL_WIDTH; i++)
               win[KSIZE-1][i] <= col_in[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_v       <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         p_v       <= 1'b0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         p_v       <= win_v;
         out_valid <= p_v;
      end
   end

   for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
      logic signed [PROD_W-1:0] prod [NTAP];
      logic signed [SUM_W-1:0]  sum;

      // Pixels are zero-extended so the multiply stays signed against the coefficient.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < NTAP; k++)
               prod[k] <= '0;
         end else if (!stall) begin
            for (int r = 0; r < KSIZE; r++)
               for (int c = 0; c < KSIZE; c++)
                  prod[r*KSIZE+c] <= PROD_W'($signed({1'b0, win[c][gi+r]}))
                                   * PROD_W'(coef[r*KSIZE+c]);
         end
      end

      always_comb begin
         sum = '0;
         for (int k = 0; k < NTAP; k++)
            sum = sum + SUM_W'(prod[k]);
      end

      assign res[gi] = post_proc(sum, shift, abs_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NOUT; j++)
            out_pixels[j] <= '0;
      end else if (!flush && !stall && p_v) begin
         for (int j = 0; j < NOUT; j++)
            out_pixels[j] <= res[j];
      end
   end

endmodule

// File: tb/tb_conv_mac_stream.sv
// Directed and randomized checks of conv_mac_stream: a 3x3/10-pixel instance for directed
// vectors and backpressure, a 5x5/12-pixel instance for random windows against a reference model.
module tb_conv_mac_stream;
   localparam int CA = 10;
   localparam int KA = 3;
   localparam int NA = CA - KA + 1;
   localparam int CB = 12;
   localparam int KB = 5;
   localparam int NB = CB - KB + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic              a_flush, a_filt_wr, a_abs_en, a_col_valid, a_col_ready, a_out_valid, a_out_ready;
   logic [3:0]        a_filt_addr, a_shift;
   logic signed [7:0] a_filt_data;
   logic [7:0]        a_col_in [CA];
   logic [7:0]        a_out_pixels [NA];

   logic              b_flush, b_filt_wr, b_abs_en, b_col_valid, b_col_ready, b_out_valid, b_out_ready;
   logic [4:0]        b_filt_addr;
   logic [3:0]        b_shift;
   logic signed [7:0] b_filt_data;
   logic [7:0]        b_col_in [CB];
   logic [7:0]        b_out_pixels [NB];

   conv_mac_stream #(.COL_WIDTH(CA), .KSIZE(KA), .PIX_W(8), .COEF_W(8)) dut_a (
      .clk(clk), .rst(rst), .flush(a_flush), .filt_wr(a_filt_wr), .filt_addr(a_filt_addr),
      .filt_data(a_filt_data), .shift(a_shift), .abs_en(a_abs_en), .col_valid(a_col_valid),
      .col_ready(a_col_ready), .col_in(a_col_in), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_pixels(a_out_pixels));

   conv_mac_stream #(.COL_WIDTH(CB), .KSIZE(KB), .PIX_W(8), .COEF_W(8)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush), .filt_wr(b_filt_wr), .filt_addr(b_filt_addr),
      .filt_data(b_filt_data), .shift(b_shift), .abs_en(b_abs_en), .col_valid(b_col_valid),
      .col_ready(b_col_ready), .col_in(b_col_in), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_pixels(b_out_pixels));

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model state shared by whichever instance is being streamed.
   int m_win [5][12];
   int m_coef [25];
   int m_col [12];
   int m_fill;
   int cur_sh, cur_ab;
   int exp_q [$];
   int n_win, n_pop;
   logic [7:0] held [NA];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      total++;
      assert (got === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_pix(input int k, input int j);
      longint s;
      s = 0;
      for (int r = 0; r < k; r++)
         for (int c = 0; c < k; c++)
            s += longint'(m_win[c][j+r]) * longint'(m_coef[r*k+c]);
      s = s >>> cur_sh;
      if (cur_ab != 0 && s < 0)
         s = -s;
      if (s < 0)
         return 0;
      if (s > 255)
         return 255;
      return int'(s);
   endfunction

   task automatic model_accept(input int k, input int cw);
      for (int c = 0; c < k - 1; c++)
         for (int i = 0; i < cw; i++)
            m_win[c][i] = m_win[c+1][i];
      for (int i = 0; i < cw; i++)
         m_win[k-1][i] = m_col[i];
      if (m_fill < k)
         m_fill++;
      if (m_fill == k) begin
         n_win++;
         for (int j = 0; j <= cw - k; j++)
            exp_q.push_back(ref_pix(k, j));
      end
   endtask

   task automatic check_pop(input string tag, input logic [31:0] got);
      int e;
      if (exp_q.size() == 0)
         e = -1;
      else
         e = exp_q.pop_front();
      check(tag, got, e);
   endtask

   // ---------------- instance A helpers ----------------
   task automatic write_a(input int addr, input int data);
      a_filt_wr   = 1'b1;
      a_filt_addr = 4'(addr);
      a_filt_data = 8'(data);
      tick;
      a_filt_wr   = 1'b0;
      m_coef[addr] = data;
   endtask

   task automatic write_all_a(input int v);
      for (int a = 0; a < KA * KA; a++)
         write_a(a, v);
   endtask

   task automatic push_a(input int k);
      for (int i = 0; i < CA; i++)
         a_col_in[i] = 8'(10 * k + i);
      a_col_valid = 1'b1;
      tick;
      a_col_valid = 1'b0;
   endtask

   task automatic flush_a;
      a_flush = 1'b1;
      tick;
      a_flush = 1'b0;
      m_fill  = 0;
   endtask

   task automatic check_row_a(input string tag, input int base, input int stp);
      for (int j = 0; j < NA; j++)
         check(tag, a_out_pixels[j], base + stp * j);
   endtask

   task automatic window_result_a(input string tag, input int pix, input int expv);
      flush_a;
      for (int i = 0; i < CA; i++)
         a_col_in[i] = 8'(pix);
      a_col_valid = 1'b1;
      tick;
      tick;
      tick;
      a_col_valid = 1'b0;
      tick;
      tick;
      check({tag, "_valid"}, a_out_valid, 1);
      check_row_a(tag, expv, 0);
   endtask

   task automatic step_a(input bit v, input bit rdy, input int k);
      for (int i = 0; i < CA; i++) begin
         m_col[i]    = (k * 37 + i * 11) % 256;
         a_col_in[i] = 8'(m_col[i]);
      end
      a_col_valid = v;
      a_out_ready = rdy;
      #1;
      if (a_out_valid && rdy) begin
         n_pop++;
         for (int j = 0; j < NA; j++)
            check_pop("bp_pix", a_out_pixels[j]);
      end
      if (v && a_col_ready)
         model_accept(KA, CA);
      @(posedge clk);
      #1;
   endtask

   // ---------------- instance B helpers ----------------
   task automatic write_b(input int addr, input int data);
      b_filt_wr   = 1'b1;
      b_filt_addr = 5'(addr);
      b_filt_data = 8'(data);
      tick;
      b_filt_wr   = 1'b0;
      m_coef[addr] = data;
   endtask

   task automatic step_b(input bit v, input bit rdy);
      for (int i = 0; i < CB; i++)
         b_col_in[i] = 8'(m_col[i]);
      b_col_valid = v;
      b_out_ready = rdy;
      #1;
      if (b_out_valid && rdy) begin
         n_pop++;
         for (int j = 0; j < NB; j++)
            check_pop("rand_pix", b_out_pixels[j]);
      end
      if (v && b_col_ready)
         model_accept(KB, CB);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the sequence completed");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_flush = 0; a_filt_wr = 0; a_filt_addr = '0; a_filt_data = '0; a_shift = '0;
      a_abs_en = 0; a_col_valid = 0; a_out_ready = 1'b1;
      b_flush = 0; b_filt_wr = 0; b_filt_addr = '0; b_filt_data = '0; b_shift = '0;
      b_abs_en = 0; b_col_valid = 0; b_out_ready = 1'b1;
      for (int i = 0; i < CA; i++) a_col_in[i] = '0;
      for (int i = 0; i < CB; i++) b_col_in[i] = '0;
      cur_sh = 0; cur_ab = 0; m_fill = 0; n_win = 0; n_pop = 0;
      repeat (2) tick;
      #2 rst = 1'b0;
      tick;
      check("rst_col_ready", a_col_ready, 1);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_pix0", a_out_pixels[0], 0);

      // Identity filter, latency and first-window behaviour.
      write_a(4, 1);
      push_a(0);
      push_a(1);
      tick;
      tick;
      check("fill_no_out", a_out_valid, 0);
      push_a(2);
      check("lat_e0", a_out_valid, 0);
      tick;
      check("lat_e1", a_out_valid, 0);
      tick;
      check("lat_e2", a_out_valid, 1);
      check_row_a("ident_w0", 11, 1);
      push_a(3);
      tick;
      tick;
      check_row_a("ident_w1", 21, 1);

      // Coefficient write on the S1 edge must not affect that window.
      push_a(4);
      a_filt_wr = 1'b1; a_filt_addr = 4'd4; a_filt_data = 8'sd3;
      tick;
      a_filt_wr = 1'b0; m_coef[4] = 3;
      tick;
      check_row_a("s1_write_old", 31, 1);
      push_a(5);
      tick;
      tick;
      check_row_a("s1_write_new", 123, 3);

      // Asynchronous reset with results in flight.
      for (int i = 0; i < CA; i++) a_col_in[i] = 8'(60 + i);
      a_col_valid = 1'b1;
      tick;
      for (int i = 0; i < CA; i++) a_col_in[i] = 8'(70 + i);
      tick;
      a_col_valid = 1'b0;
      tick;
      check("pre_rst_valid", a_out_valid, 1);
      check_row_a("pre_rst_row", 153, 3);
      #3 rst = 1'b1;
      #1;
      check("async_rst_valid", a_out_valid, 0);
      check_row_a("async_rst_pix", 0, 0);
      tick;
      tick;
      #2 rst = 1'b0;
      tick;
      check("post_rst_ready", a_col_ready, 1);
      check("post_rst_valid", a_out_valid, 0);
      for (int k = 0; k < 25; k++) m_coef[k] = 0;
      push_a(1);
      push_a(2);
      for (int t = 0; t < 3; t++) begin
         tick;
         check("post_rst_no_out", a_out_valid, 0);
      end

      // Saturation, abs and shift.
      write_all_a(1);
      window_result_a("sat_hi", 200, 255);
      write_all_a(-1);
      window_result_a("neg_clamp", 10, 0);
      a_abs_en = 1'b1;
      window_result_a("abs_neg", 10, 90);
      a_abs_en = 1'b0;
      write_all_a(1);
      a_shift = 4'd3;
      window_result_a("shift3", 8, 9);
      write_all_a(0);
      write_a(0, -3);
      a_shift = 4'd1;
      window_result_a("floor_clamp", 1, 0);
      a_abs_en = 1'b1;
      window_result_a("floor_abs", 1, 2);
      a_abs_en = 1'b0;
      a_shift  = 4'd0;

      // Flush after 2 accepts; flush beats a same-cycle accept; filt_wr still lands.
      write_all_a(0);
      write_a(4, 1);
      flush_a;
      push_a(1);
      push_a(2);
      for (int i = 0; i < CA; i++) a_col_in[i] = 8'(90 + i);
      a_flush = 1'b1; a_col_valid = 1'b1;
      a_filt_wr = 1'b1; a_filt_addr = 4'd4; a_filt_data = 8'sd2;
      #1;
      check("flush_blocks_ready", a_col_ready, 0);
      tick;
      a_flush = 1'b0; a_col_valid = 1'b0; a_filt_wr = 1'b0; m_coef[4] = 2;
      push_a(3);
      push_a(4);
      for (int t = 0; t < 3; t++) begin
         tick;
         check("flush_no_out", a_out_valid, 0);
      end
      push_a(5);
      tick;
      tick;
      check("flush_third_valid", a_out_valid, 1);
      check_row_a("flush_third_row", 82, 2);

      // Backpressure against the reference model.
      write_a(0, 1); write_a(1, 0); write_a(2, -1);
      write_a(3, 2); write_a(4, 1); write_a(5, 0);
      write_a(6, 0); write_a(7, 1); write_a(8, 1);
      a_shift = 4'd1; cur_sh = 1; cur_ab = 0;
      flush_a;
      exp_q.delete();
      n_win = 0;
      n_pop = 0;
      for (int k = 0; k < 8; k++)
         step_a(1'b1, 1'b1, k);
      check("bp_valid_before_stall", a_out_valid, 1);
      for (int j = 0; j < NA; j++)
         held[j] = a_out_pixels[j];
      for (int s = 0; s < 5; s++) begin
         step_a(1'b1, 1'b0, 8);
         check("bp_col_ready", a_col_ready, 0);
         for (int j = 0; j < NA; j++)
            check("bp_hold", a_out_pixels[j], held[j]);
      end
      for (int k = 8; k < 14; k++)
         step_a(1'b1, 1'b1, k);
      for (int t = 0; t < 6; t++)
         step_a(1'b0, 1'b1, 0);
      check("bp_result_count", n_pop, 12);
      check("bp_queue_empty", exp_q.size(), 0);
      check("bp_idle_valid", a_out_valid, 0);

      // KSIZE=5 instance: random filters and random handshakes, 500 windows per abs_en setting.
      for (int p = 0; p < 2; p++) begin
         b_abs_en = (p == 1);
         b_shift  = 4'd5;
         cur_sh   = 5;
         cur_ab   = p;
         for (int a = 0; a < KB * KB; a++)
            write_b(a, int'($urandom_range(0, 6)) - 3);
         b_flush = 1'b1;
         tick;
         b_flush = 1'b0;
         m_fill  = 0;
         exp_q.delete();
         n_win = 0;
         n_pop = 0;
         for (int it = 0; it < 20000 && n_win < 500; it++) begin
            for (int i = 0; i < CB; i++)
               m_col[i] = int'($urandom_range(0, 255));
            step_b($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0);
         end
         for (int t = 0; t < 8; t++)
            step_b(1'b0, 1'b1);
         check("rand_windows", n_win, 500);
         check("rand_results", n_pop, 500);
         check("rand_queue_empty", exp_q.size(), 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
